// File: rtl/raster_reader_640.sv
// raster_reader_640
// Frame-buffer raster reader. On a start pulse it walks the frame buffer in
// row-major order (one linear address per issued read). It retimes the RAM
// returns (1-cycle latency) into a valid/ready pixel stream tagged with
// column, row, end-of-line and end-of-frame.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle frame request, ignored while busy or on done
//   busy, done        frame in progress / one-cycle completion pulse
//   rd_en, rd_addr    RAM read strobe and address
//   rd_data           RAM data, valid the cycle after rd_en
//   m_valid, m_ready  output stream handshake
//   m_data, m_col, m_row, m_eol, m_eof   output beat payload and tags
module raster_reader_640 #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [9:0]        m_col,
  output logic [9:0]        m_row,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int               NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [9:0]       LAST_COL  = 10'(IMG_W - 1);
  localparam logic [9:0]       LAST_ROW  = 10'(IMG_H - 1);
  localparam int               EW        = DATA_W + 22;  // {data, col, row, eol, eof}

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [9:0]  col_cnt;
  logic [9:0]  row_cnt;

  // Tags travel one stage behind the read so they line up with rd_data.
  logic        inflight;
  logic [9:0]  tag_col;
  logic [9:0]  tag_row;
  logic        tag_eol;
  logic        tag_eof;

  // Two-entry output FIFO.
  logic [EW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic push;
  logic pop;
  logic credit_ok;

  assign push    = inflight;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & m_ready;

  // A read may issue only if its return is guaranteed a FIFO slot, counting
  // the beat that leaves this cycle. Including pop keeps one beat per cycle.
  assign credit_ok = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign rd_en     = (state == RUN) && credit_ok;

  assign {m_data, m_col, m_row, m_eol, m_eof} = fifo_mem[rd_ptr];

  // Control FSM and issue counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_addr <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is already IDLE; a start there is still ignored.
          if (start && !done) begin
            state   <= RUN;
            busy    <= 1'b1;
            rd_addr <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (col_cnt == LAST_COL) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 10'd1;
            end else begin
              col_cnt <= col_cnt + 10'd1;
            end
            if (rd_addr == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_eof) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tag pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      tag_col  <= '0;
      tag_row  <= '0;
      tag_eol  <= 1'b0;
      tag_eof  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        tag_col <= col_cnt;
        tag_row <= row_cnt;
        tag_eol <= (col_cnt == LAST_COL);
        tag_eof <= (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
      end
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the stream outputs read back as zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (reset) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr == 1'(gi))) begin
          fifo_mem[gi] <= {rd_data, tag_col, tag_row, tag_eol, tag_eof};
        end
      end
    end
  endgenerate

endmodule
